// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-flight branch prediction tracker, mispredict redirect and predictor training
//
// Purpose:
//   Holds every ID-stage prediction in a small FIFO until the ALU stage resolves the oldest one.
//   The resolution is compared against the prediction. A mispredict empties the FIFO, pulses
//   redirect/flush and bumps a saturating counter. Every resolution emits a predictor training update.
//
// Ports:
//   i_clock, i_reset            rising-edge clock, synchronous active-high reset
//   i_pred_*                    prediction push {pc, taken, target}; o_pred_ready = push accepted
//   i_res_*                     resolution of the oldest entry {taken, target}
//   o_redirect_valid/_pc        one-cycle PC redirect to the correct path
//   o_flush                     one-cycle flush of IF/ID and ID/EX
//   o_upd_valid/_idx/_taken     one-cycle predictor training request
//   o_mispredict_count          saturating mispredict counter
//   o_err_underflow             sticky: resolution arrived with nothing outstanding
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_pred_valid,
  input  logic [PC_W-1:0]  i_pred_pc,
  input  logic             i_pred_taken,
  input  logic [PC_W-1:0]  i_pred_target,
  output logic             o_pred_ready,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  input  logic [PC_W-1:0]  i_res_target,
  output logic             o_redirect_valid,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_upd_valid,
  output logic [IDX_W-1:0] o_upd_idx,
  output logic             o_upd_taken,
  output logic [CNT_W-1:0] o_mispredict_count,
  output logic             o_err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PC_W-1:0]  r_pc_mem     [DEPTH];
  logic             r_taken_mem  [DEPTH];
  logic [PC_W-1:0]  r_target_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_taken;
  logic [PC_W-1:0]  w_head_target;
  logic             w_pop;
  logic             w_push;
  logic             w_mispredict;
  logic [PC_W-1:0]  w_correct_pc;

  assign w_head_pc     = r_pc_mem[r_rd_ptr];
  assign w_head_taken  = r_taken_mem[r_rd_ptr];
  assign w_head_target = r_target_mem[r_rd_ptr];

  // A resolution with nothing outstanding is not a pop; a push in the same cycle does not count,
  // since a new entry only becomes visible the cycle after it is written.
  assign w_pop = i_res_valid && (r_count != '0);

  // Target only matters when both sides agree the branch is taken.
  assign w_mispredict = w_pop &&
                        ((i_res_taken != w_head_taken) ||
                         (i_res_taken && w_head_taken && (i_res_target != w_head_target)));

  assign w_correct_pc = i_res_taken ? i_res_target : (w_head_pc + PC_W'(4));

  // A push alongside a mispredict is wrong-path, and during flush the ID stage still holds a
  // wrong-path instruction, so both cases refuse the push.
  assign o_pred_ready = (r_count < DEPTH_CNT) && !w_mispredict && !o_flush;
  assign w_push       = i_pred_valid && o_pred_ready;

  // Entry storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]     <= i_pred_pc;
      r_taken_mem[r_wr_ptr]  <= i_pred_taken;
      r_target_mem[r_wr_ptr] <= i_pred_target;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr           <= '0;
      r_rd_ptr           <= '0;
      r_count            <= '0;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= '0;
      o_flush            <= 1'b0;
      o_upd_valid        <= 1'b0;
      o_upd_idx          <= '0;
      o_upd_taken        <= 1'b0;
      o_mispredict_count <= '0;
      o_err_underflow    <= 1'b0;
    end else begin
      o_redirect_valid <= w_mispredict;
      o_flush          <= w_mispredict;
      o_upd_valid      <= w_pop;

      if (w_mispredict) begin
        o_redirect_pc <= w_correct_pc;
      end

      if (w_pop) begin
        o_upd_idx   <= w_head_pc[IDX_W+1:2];
        o_upd_taken <= i_res_taken;
      end

      if (i_res_valid && (r_count == '0)) begin
        o_err_underflow <= 1'b1;
      end

      if (w_mispredict) begin
        // Everything younger than the mispredicted branch is wrong-path.
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
        if (o_mispredict_count != '1) begin
          o_mispredict_count <= o_mispredict_count + CNT_W'(1);
        end
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  logic             i_clock = 1'b0;
  logic             i_reset;
  logic             i_pred_valid;
  logic [PC_W-1:0]  i_pred_pc;
  logic             i_pred_taken;
  logic [PC_W-1:0]  i_pred_target;
  logic             o_pred_ready;
  logic             i_res_valid;
  logic             i_res_taken;
  logic [PC_W-1:0]  i_res_target;
  logic             o_redirect_valid;
  logic [PC_W-1:0]  o_redirect_pc;
  logic             o_flush;
  logic             o_upd_valid;
  logic [IDX_W-1:0] o_upd_idx;
  logic             o_upd_taken;
  logic [CNT_W-1:0] o_mispredict_count;
  logic             o_err_underflow;

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken),
    .i_pred_target(i_pred_target), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
    .o_upd_valid(o_upd_valid), .o_upd_idx(o_upd_idx), .o_upd_taken(o_upd_taken),
    .o_mispredict_count(o_mispredict_count), .o_err_underflow(o_err_underflow)
  );

  always #5 i_clock = ~i_clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a queue of outstanding predictions plus expected registered outputs.
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;
  ent_t q[$];

  logic        a_ready;
  logic        e_ready;
  logic        e_redir, e_flush, e_upd, e_utaken, e_err;
  logic [31:0] e_rpc;
  logic [2:0]  e_idx;
  int          e_mcnt;

  task automatic model_reset();
    q.delete();
    e_redir = 0; e_flush = 0; e_upd = 0; e_utaken = 0; e_err = 0;
    e_rpc = 0; e_idx = 0; e_mcnt = 0; e_ready = 1;
  endtask

  task automatic do_reset();
    i_reset = 1; i_pred_valid = 0; i_pred_pc = 0; i_pred_taken = 0; i_pred_target = 0;
    i_res_valid = 0; i_res_taken = 0; i_res_target = 0;
    @(posedge i_clock); @(posedge i_clock); #1;
    i_reset = 0;
    model_reset();
  endtask

  // One clock: drive inputs, sample pred_ready before the edge, advance the model, land at edge+1.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                      input logic rv, input logic rt, input logic [31:0] rtgt);
    ent_t h;
    bit   pop, mis, push;
    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptgt;
    i_res_valid = rv; i_res_taken = rt; i_res_target = rtgt;
    #1;
    a_ready = o_pred_ready;
    pop = rv && (q.size() > 0);
    h = '{pc: 32'd0, tk: 1'b0, tg: 32'd0};
    if (pop) h = q[0];
    mis = pop && ((rt != h.tk) || (rt && (rtgt != h.tg)));
    e_ready = (q.size() < DEPTH) && !mis && !e_flush;
    push = pv && e_ready;
    @(posedge i_clock); #1;
    e_redir = mis;
    e_flush = mis;
    e_upd   = pop;
    if (mis) e_rpc = rt ? rtgt : h.pc + 32'd4;
    if (pop) begin
      e_idx = h.pc[4:2];
      e_utaken = rt;
    end
    if (rv && !pop) e_err = 1;
    if (mis) begin
      q.delete();
      if (e_mcnt != 15) e_mcnt++;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc: ppc, tk: pt, tg: ptgt});
    end
    i_pred_valid = 0; i_res_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) idle();
    n_total++; if (a_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", a_ready); else n_pass++;
    n_total++; if (o_redirect_valid !== 1'b0) $display("FAIL reset_redirect_valid got %0b want 0", o_redirect_valid); else n_pass++;
    n_total++; if (o_redirect_pc !== 32'd0) $display("FAIL reset_redirect_pc got %0h want 0", o_redirect_pc); else n_pass++;
    n_total++; if (o_flush !== 1'b0) $display("FAIL reset_flush got %0b want 0", o_flush); else n_pass++;
    n_total++; if (o_upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %0b want 0", o_upd_valid); else n_pass++;
    n_total++; if (o_upd_idx !== 3'd0) $display("FAIL reset_upd_idx got %0d want 0", o_upd_idx); else n_pass++;
    n_total++; if (o_upd_taken !== 1'b0) $display("FAIL reset_upd_taken got %0b want 0", o_upd_taken); else n_pass++;
    n_total++; if (o_mispredict_count !== 4'd0) $display("FAIL reset_mcount got %0d want 0", o_mispredict_count); else n_pass++;
    n_total++; if (o_err_underflow !== 1'b0) $display("FAIL reset_err got %0b want 0", o_err_underflow); else n_pass++;
  endtask

  task automatic test_correct_pop();
    step(1, 32'h100, 1, 32'h140, 0, 0, 0);
    n_total++; if (a_ready !== 1'b1) $display("FAIL cp_push_ready got %0b want 1", a_ready); else n_pass++;
    step(0, 0, 0, 0, 1, 1, 32'h140);
    n_total++; if (o_upd_valid !== 1'b1) $display("FAIL cp_upd_valid got %0b want 1", o_upd_valid); else n_pass++;
    n_total++; if (o_upd_idx !== 3'd0) $display("FAIL cp_upd_idx got %0d want 0", o_upd_idx); else n_pass++;
    n_total++; if (o_upd_taken !== 1'b1) $display("FAIL cp_upd_taken got %0b want 1", o_upd_taken); else n_pass++;
    n_total++; if (o_flush !== 1'b0) $display("FAIL cp_flush got %0b want 0", o_flush); else n_pass++;
    n_total++; if (o_redirect_valid !== 1'b0) $display("FAIL cp_redirect got %0b want 0", o_redirect_valid); else n_pass++;
    idle();
    n_total++; if (o_upd_valid !== 1'b0) $display("FAIL cp_upd_one_cycle got %0b want 0", o_upd_valid); else n_pass++;
  endtask

  task automatic test_mispredict_flush();
    step(1, 32'h20, 0, 32'h60, 0, 0, 0);
    step(1, 32'h24, 0, 32'h60, 0, 0, 0);
    step(1, 32'h28, 0, 32'h60, 0, 0, 0);
    // Resolve first as taken with a simultaneous push: the push must be refused.
    step(1, 32'h2c, 0, 32'h60, 1, 1, 32'h80);
    n_total++; if (a_ready !== 1'b0) $display("FAIL mp_ready_on_mispredict got %0b want 0", a_ready); else n_pass++;
    n_total++; if (o_flush !== 1'b1) $display("FAIL mp_flush got %0b want 1", o_flush); else n_pass++;
    n_total++; if (o_redirect_valid !== 1'b1) $display("FAIL mp_redirect_valid got %0b want 1", o_redirect_valid); else n_pass++;
    n_total++; if (o_redirect_pc !== 32'h80) $display("FAIL mp_redirect_pc got %0h want 80", o_redirect_pc); else n_pass++;
    n_total++; if (o_mispredict_count !== 4'd1) $display("FAIL mp_mcount got %0d want 1", o_mispredict_count); else n_pass++;
    n_total++; if (o_upd_valid !== 1'b1 || o_upd_taken !== 1'b1) $display("FAIL mp_upd got v=%0b t=%0b want v=1 t=1", o_upd_valid, o_upd_taken); else n_pass++;
    // Flush cycle: push refused.
    step(1, 32'h80, 0, 32'h90, 0, 0, 0);
    n_total++; if (a_ready !== 1'b0) $display("FAIL mp_ready_in_flush got %0b want 0", a_ready); else n_pass++;
    n_total++; if (o_flush !== 1'b0 || o_redirect_valid !== 1'b0) $display("FAIL mp_pulse_width got f=%0b r=%0b want 0 0", o_flush, o_redirect_valid); else n_pass++;
  endtask

  task automatic test_fill_wrap();
    logic [31:0] order [9];
    order = '{32'h408, 32'h40c, 32'h410, 32'h500, 32'h504, 32'h508, 32'h50c, 32'h510, 32'h514};
    // FIFO must be empty here: exactly DEPTH pushes are accepted.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 32'h400 + 32'(4 * i), 0, 32'h0, 0, 0, 0);
      n_total++; if (a_ready !== 1'b1) $display("FAIL fill_ready_%0d got %0b want 1", i, a_ready); else n_pass++;
    end
    step(1, 32'h410, 0, 32'h0, 1, 0, 32'h0);
    n_total++; if (a_ready !== 1'b0) $display("FAIL full_ready got %0b want 0", a_ready); else n_pass++;
    n_total++; if (o_upd_valid !== 1'b1 || o_upd_idx !== 3'd0) $display("FAIL full_pop got v=%0b idx=%0d want v=1 idx=0", o_upd_valid, o_upd_idx); else n_pass++;
    step(1, 32'h410, 0, 32'h0, 0, 0, 0);
    n_total++; if (a_ready !== 1'b1) $display("FAIL refill_ready got %0b want 1", a_ready); else n_pass++;
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++; if (o_upd_idx !== 3'd1) $display("FAIL pop_404 idx got %0d want 1", o_upd_idx); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      logic [31:0] want_pc;
      want_pc = order[i];
      if (i < 6) step(1, 32'h500 + 32'(4 * i), 0, 32'h0, 1, 0, 0);
      else       step(0, 0, 0, 0, 1, 0, 0);
      n_total++;
      if (o_upd_valid !== 1'b1 || o_upd_idx !== want_pc[4:2] || o_flush !== 1'b0)
        $display("FAIL wrap_order_%0d got v=%0b idx=%0d f=%0b want v=1 idx=%0d f=0", i, o_upd_valid, o_upd_idx, o_flush, want_pc[4:2]);
      else n_pass++;
    end
  endtask

  task automatic test_target_mispredict();
    step(1, 32'h1f0, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h204);
    n_total++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h204) $display("FAIL tgt_redirect got v=%0b pc=%0h want v=1 pc=204", o_redirect_valid, o_redirect_pc); else n_pass++;
    n_total++; if (o_mispredict_count !== 4'd2) $display("FAIL tgt_mcount got %0d want 2", o_mispredict_count); else n_pass++;
    idle();
    step(1, 32'h300, 1, 32'h380, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h380);
    n_total++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h304) $display("FAIL dir_redirect got v=%0b pc=%0h want v=1 pc=304", o_redirect_valid, o_redirect_pc); else n_pass++;
    n_total++; if (o_mispredict_count !== 4'd3) $display("FAIL dir_mcount got %0d want 3", o_mispredict_count); else n_pass++;
    idle();
  endtask

  task automatic test_underflow();
    step(0, 0, 0, 0, 1, 1, 32'h40);
    n_total++; if (o_err_underflow !== 1'b1) $display("FAIL uf_err got %0b want 1", o_err_underflow); else n_pass++;
    n_total++; if (o_upd_valid !== 1'b0 || o_redirect_valid !== 1'b0 || o_flush !== 1'b0)
      $display("FAIL uf_no_pulse got u=%0b r=%0b f=%0b want 0 0 0", o_upd_valid, o_redirect_valid, o_flush); else n_pass++;
    idle(); idle();
    n_total++; if (o_err_underflow !== 1'b1) $display("FAIL uf_sticky got %0b want 1", o_err_underflow); else n_pass++;
    // Same-cycle push and pop on empty: push lands, pop is an underflow.
    step(1, 32'h608, 0, 32'h0, 1, 0, 0);
    n_total++; if (a_ready !== 1'b1 || o_upd_valid !== 1'b0) $display("FAIL uf_same_cycle got ready=%0b upd=%0b want 1 0", a_ready, o_upd_valid); else n_pass++;
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++; if (o_upd_valid !== 1'b1 || o_upd_idx !== 3'd2) $display("FAIL uf_later_pop got v=%0b idx=%0d want 1 2", o_upd_valid, o_upd_idx); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    n_total++; if (o_err_underflow !== 1'b0 || o_mispredict_count !== 4'd0) $display("FAIL sat_reset got err=%0b cnt=%0d want 0 0", o_err_underflow, o_mispredict_count); else n_pass++;
    for (int k = 1; k <= 17; k++) begin
      step(1, 32'h700, 1, 32'h740, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      idle();
      n_total++;
      if (o_mispredict_count !== CNT_W'((k > 15) ? 15 : k))
        $display("FAIL sat_count_%0d got %0d want %0d", k, o_mispredict_count, (k > 15) ? 15 : k);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] ppc, ptgt, rtgt;
      pv   = ($urandom_range(0, 9) < 6);
      ppc  = 32'($urandom_range(0, 255)) << 2;
      pt   = 1'($urandom);
      ptgt = 32'($urandom_range(0, 15)) << 4;
      rv   = ($urandom_range(0, 9) < 4);
      rt   = 1'($urandom);
      rtgt = 32'($urandom_range(0, 15)) << 4;
      if (q.size() > 0) begin
        if ($urandom_range(0, 9) < 7) rt = q[0].tk;
        if ($urandom_range(0, 9) < 8) rtgt = q[0].tg;
      end
      step(pv, ppc, pt, ptgt, rv, rt, rtgt);
      n_total++; if (a_ready !== e_ready) $display("FAIL rnd_ready_%0d got %0b want %0b", n, a_ready, e_ready); else n_pass++;
      n_total++; if (o_redirect_valid !== e_redir || o_flush !== e_flush)
        $display("FAIL rnd_redirect_%0d got r=%0b f=%0b want %0b", n, o_redirect_valid, o_flush, e_redir); else n_pass++;
      if (e_redir) begin
        n_total++; if (o_redirect_pc !== e_rpc) $display("FAIL rnd_rpc_%0d got %0h want %0h", n, o_redirect_pc, e_rpc); else n_pass++;
      end
      n_total++; if (o_upd_valid !== e_upd) $display("FAIL rnd_upd_%0d got %0b want %0b", n, o_upd_valid, e_upd); else n_pass++;
      if (e_upd) begin
        n_total++; if (o_upd_idx !== e_idx || o_upd_taken !== e_utaken)
          $display("FAIL rnd_upd_data_%0d got idx=%0d t=%0b want idx=%0d t=%0b", n, o_upd_idx, o_upd_taken, e_idx, e_utaken); else n_pass++;
      end
      n_total++; if (o_mispredict_count !== CNT_W'(e_mcnt) || o_err_underflow !== e_err)
        $display("FAIL rnd_state_%0d got cnt=%0d err=%0b want cnt=%0d err=%0b", n, o_mispredict_count, o_err_underflow, e_mcnt, e_err); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    step(1, 32'h800, 0, 32'h0, 0, 0, 0);
    step(1, 32'h804, 0, 32'h0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0);
    n_total++; if (o_upd_valid !== 1'b0 || o_err_underflow !== 1'b1)
      $display("FAIL midreset_empty got upd=%0b err=%0b want 0 1", o_upd_valid, o_err_underflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct_pop();
    test_mispredict_flush();
    test_fill_wrap();
    test_target_mispredict();
    test_underflow();
    test_saturation();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch prediction made in the ID stage until the ALU stage resolves it, detects mispredictions, and produces the PC redirect and pipeline flush. It is the resolution end of the prediction path. The front end pushes {pc, predicted direction, predicted target} when it predicts. The ALU pops the oldest entry when the branch resolves. Every resolution drives a training update back to the 2-bit predictor table.

## Interface
- DEPTH, 4: in-flight prediction FIFO entries (power of two, ≥2)
- PC_W, 32: PC width
- IDX_W, 3: predictor table index width (index = pc[IDX_W+1:2])
- CNT_W, 16: mispredict counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  ID stage issues a branch prediction this cycle
- pred_pc  in  PC_W  PC of the predicted branch
- pred_taken  in  1  predicted direction (1 = taken)
- pred_target  in  PC_W  target from the ID-stage adder
- pred_ready  out  1  push accepted this cycle (combinational)
- res_valid  in  1  ALU stage resolves the oldest outstanding branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual target from the ALU-stage adder
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  PC_W  corrected fetch address
- flush  out  1  one-cycle pulse: clear IF/ID and ID/EX pipeline registers
- upd_valid  out  1  one-cycle pulse: predictor training request
- upd_idx  out  IDX_W  predictor entry to train
- upd_taken  out  1  actual outcome for training
- mispredict_count  out  CNT_W  saturating mispredict count
- err_underflow  out  1  sticky: resolution arrived with the FIFO empty

## Operation
- FIFO entry = {pc, taken, target}. Head = oldest entry. Pointers are log2(DEPTH) bits with wrap-around. count ranges 0..DEPTH.
- pred_ready = (count < DEPTH) && !mispredict_now && !flush. A push occurs when pred_valid && pred_ready.
- A push and a correct pop in the same cycle leaves count unchanged. Both pointers advance.
- Pop (res_valid && count>0):
  - mispredict_now = (res_taken != head.taken) || (res_taken && head.taken && res_target != head.target).
  - Correct-path PC = res_taken ? res_target : head.pc + 4. Modulo 2^PC_W.
- On mispredict:
  - Empty the entire FIFO (count=0, rd_ptr=wr_ptr). Younger entries are wrong-path.
  - Discard any simultaneous push.
  - Register redirect_valid=1, flush=1, redirect_pc=correct-path PC.
  - Increment mispredict_count. It saturates at all-ones.
- Every pop, correct or not, registers upd_valid=1, upd_idx=head.pc[IDX_W+1:2], upd_taken=res_taken.
- res_valid with count==0: no pop, no redirect, no update. Set err_underflow and hold it until reset.
- While flush=1, pushes are refused. The ID stage still holds a wrong-path instruction that cycle.
- Reset mid-operation discards all entries and pending pulses.

## Timing
- All outputs except pred_ready are registered. Latency from res_valid to redirect/flush/upd pulses is 1 cycle.
- Each pulse is high for exactly one cycle per resolution. Back-to-back resolutions give back-to-back upd_valid pulses.
- Pipeline: resolution in cycle T, then redirect/flush in T+1. The first correct-path fetch is in T+2. Pushes resume in T+2.
- Reset values: pred_ready=1 (after reset deasserts), redirect_valid=0, redirect_pc=0, flush=0, upd_valid=0, upd_idx=0, upd_taken=0, mispredict_count=0, err_underflow=0, count=0, pointers=0.
- A pushed entry is poppable the cycle after its push. A same-cycle push and pop on an empty FIFO is treated as an underflow.

## Test plan
- Reset, then hold idle 3 cycles. Required: all outputs at reset values, pred_ready=1.
- Push pc=0x100 (taken, target 0x140). Resolve taken with target 0x140. Required: next cycle upd_valid=1, upd_idx=0, upd_taken=1, no flush, count back to 0.
- Push pc=0x20 (not-taken), pc=0x24, pc=0x28. Resolve the first as taken, target 0x80. Required: next cycle flush=1, redirect_pc=0x80, mispredict_count=1, FIFO empty. A push in the flush cycle is refused.
- Predict taken with target 0x200. Resolve taken with target 0x204. Required: mispredict, redirect_pc=0x204. Then predict taken and resolve not-taken at pc=0x300. Required: redirect_pc=0x304.
- Fill DEPTH entries. Required: pred_ready=0. Then a same-cycle push and correct pop: pop accepted, push refused, count=DEPTH-1. Further push/pop cycles cover pointer wrap and FIFO order across the wrap.
- res_valid on an empty FIFO. Required: err_underflow=1 sticky, no upd_valid, no redirect. Also force 2^CNT_W+1 mispredicts with CNT_W=4: counter holds at 15.
